maj5_fault_monitor: RTL and testbench

//  Sits directly downstream of the 5-input majority voter (Maj) in the 5MR datapath.

---
 rtl/maj5_mon_if.sv | 26 ++
 rtl/maj5_fault_monitor.sv | 143 ++++++++++++++
 tb/tb_maj5_fault_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/maj5_mon_if.sv
// Bundle between the 5MR voter stage and the fault monitor: replica/vote sample in,
// registered vote and health status out.
interface maj5_mon_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic             a, b, c, d, e;
  logic             z;
  logic             clr_fault;
  logic             z_q;
  logic             out_valid;
  logic [4:0]       fault;
  logic             degraded;
  logic             fatal;
  logic             voter_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, a, b, c, d, e, z, clr_fault,
    input  z_q, out_valid, fault, degraded, fatal, voter_err, err_count
  );
  modport slave (
    input  in_valid, a, b, c, d, e, z, clr_fault,
    output z_q, out_valid, fault, degraded, fatal, voter_err, err_count
  );
endinterface

// File: rtl/maj5_fault_monitor.sv
// Health monitor behind the 5-input majority voter: registers the vote, tracks
// consecutive disagreement per replica, latches failed replicas and cross-checks the voter.

module maj5_replica_fsm #(
  parameter int MISS_THRESH = 3,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic clr,
  input  logic mis,
  output logic failed
);
  localparam logic [1:0] HEALTHY = 2'd0;
  localparam logic [1:0] SUSPECT = 2'd1;
  localparam logic [1:0] FAILED  = 2'd2;
  localparam logic [CNT_W-1:0] THR = CNT_W'(MISS_THRESH);

  logic [1:0]       st_d, st_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (clr) begin
      st_d  = HEALTHY;
      cnt_d = '0;
    end else if (vld) begin
      case (st_q)
        HEALTHY: begin
          if (mis) begin
            cnt_d = CNT_W'(1);
            st_d  = (MISS_THRESH == 1) ? FAILED : SUSPECT;
          end else begin
            cnt_d = '0;
          end
        end
        SUSPECT: begin
          if (!mis) begin
            st_d  = HEALTHY;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == THR) st_d = FAILED;
          end
        end
        default: ; // FAILED holds state and count until cleared
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= HEALTHY;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign failed = (st_q == FAILED);
endmodule

module maj5_fault_monitor #(
  parameter int MISS_THRESH = 3,
  parameter int CNT_W       = 4,
  parameter int ERR_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  maj5_mon_if.slave   bus
);
  logic [4:0]       rep, mis, fault;
  logic [2:0]       rep_ones, fault_ones;
  logic             zout_d, zout_q;
  logic             vld_d, vld_q;
  logic             verr_d, verr_q;
  logic [ERR_W-1:0] err_d, err_q;

  assign rep = {bus.e, bus.d, bus.c, bus.b, bus.a};
  assign mis = rep ^ {5{bus.z}};

  for (genvar g = 0; g < 5; g++) begin : g_rep
    maj5_replica_fsm #(.MISS_THRESH(MISS_THRESH), .CNT_W(CNT_W)) u_fsm (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld    (bus.in_valid),
      .clr    (bus.clr_fault),
      .mis    (mis[g]),
      .failed (fault[g])
    );
  end

  always_comb begin
    rep_ones   = '0;
    fault_ones = '0;
    for (int i = 0; i < 5; i++) begin
      rep_ones   = rep_ones   + 3'(rep[i]);
      fault_ones = fault_ones + 3'(fault[i]);
    end
  end

  always_comb begin
    zout_d = bus.z;
    vld_d  = bus.in_valid;
    verr_d = verr_q;
    err_d  = err_q;
    if (bus.clr_fault)
      verr_d = 1'b0;
    else if (bus.in_valid && (bus.z != (rep_ones >= 3'd3)))
      verr_d = 1'b1;
    // err_count ignores clr_fault: the sample is judged against pre-clear health
    if (bus.in_valid && |(mis & ~fault) && (err_q != '1))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zout_q <= 1'b0;
      vld_q  <= 1'b0;
      verr_q <= 1'b0;
      err_q  <= '0;
    end else begin
      zout_q <= zout_d;
      vld_q  <= vld_d;
      verr_q <= verr_d;
      err_q  <= err_d;
    end
  end

  assign bus.z_q       = zout_q;
  assign bus.out_valid = vld_q;
  assign bus.fault     = fault;
  assign bus.degraded  = |fault;
  assign bus.fatal     = (fault_ones >= 3'd3);
  assign bus.voter_err = verr_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_maj5_fault_monitor.sv
// Random + directed bench for maj5_fault_monitor against a run-length reference model;
// a second instance with ERR_W=2 exercises counter saturation.
module tb_maj5_fault_monitor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maj5_mon_if #(.ERR_W(8)) bus  ();
  maj5_mon_if #(.ERR_W(2)) bus2 ();

  maj5_fault_monitor #(.MISS_THRESH(3), .CNT_W(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  maj5_fault_monitor #(.MISS_THRESH(3), .CNT_W(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_chk = 0;
  int n_err = 0;

  // reference model: length of current mismatch run per replica, failed flags
  int run   [5];
  bit mfail [5];
  bit m_zq, m_ov, m_verr;
  int nerr_true;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] mfault();
    logic [4:0] f = '0;
    for (int i = 0; i < 5; i++) f[i] = mfail[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin run[i] = 0; mfail[i] = 0; end
    m_zq = 0; m_ov = 0; m_verr = 0; nerr_true = 0;
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [4:0] r,
                            input bit z, input bit clr);
    bit any_live;
    int ones;
    if (!rst) begin model_reset(); return; end
    m_zq = z;
    m_ov = v;
    any_live = 0;
    ones = $countones(r);
    for (int i = 0; i < 5; i++)
      if (!mfail[i] && (r[i] != z)) any_live = 1;
    if (v && any_live) nerr_true++;
    if (clr) begin
      for (int i = 0; i < 5; i++) begin run[i] = 0; mfail[i] = 0; end
      m_verr = 0;
    end else if (v) begin
      for (int i = 0; i < 5; i++) begin
        if (mfail[i]) continue;
        if (r[i] != z) begin
          run[i]++;
          if (run[i] >= 3) mfail[i] = 1;
        end else run[i] = 0;
      end
      if (z != (ones >= 3)) m_verr = 1;
    end
  endtask

  task automatic check_all();
    logic [4:0] f;
    f = mfault();
    chk("z_q",       32'(bus.z_q),       32'(m_zq));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("fault",     32'(bus.fault),     32'(f));
    chk("degraded",  32'(bus.degraded),  32'(f != 0));
    chk("fatal",     32'(bus.fatal),     32'($countones(f) >= 3));
    chk("voter_err", 32'(bus.voter_err), 32'(m_verr));
    chk("err_count", 32'(bus.err_count), 32'((nerr_true > 255) ? 255 : nerr_true));
    chk("err_sat2",  32'(bus2.err_count), 32'((nerr_true > 3) ? 3 : nerr_true));
    chk("fault2",    32'(bus2.fault),    32'(f));
  endtask

  // r is {e,d,c,b,a}
  task automatic step(input bit rst, input bit v, input logic [4:0] r,
                      input bit z, input bit clr);
    rst_n = rst;
    {bus.e, bus.d, bus.c, bus.b, bus.a}      = r;
    {bus2.e, bus2.d, bus2.c, bus2.b, bus2.a} = r;
    bus.in_valid = v;   bus2.in_valid = v;
    bus.z = z;          bus2.z = z;
    bus.clr_fault = clr; bus2.clr_fault = clr;
    @(posedge clk);
    model_step(rst, v, r, z, clr);
    #1;
    check_all();
  endtask

  initial begin
    logic [4:0] r;
    bit base, zz;
    model_reset();

    // reset with random inputs
    for (int k = 0; k < 2; k++)
      step(0, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_err", 32'(bus.err_count), 32'd0);

    // single transient on c,e then clean
    step(1, 1, 5'b01011, 1, 0);
    step(1, 1, 5'b11111, 1, 0);
    step(1, 1, 5'b11111, 0, 0);
    chk("trans_fault", 32'(bus.fault), 32'd0);
    chk("trans_zq",    32'(bus.z_q),   32'd0);
    step(1, 1, 5'b11111, 1, 0);
    chk("trans_err",   32'(bus.err_count), 32'd2);

    // e stuck 1 against z=0 with valid gaps
    step(1, 0, 5'b00000, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 5'b10000, 0, 0);
      if (k < 2) step(1, 0, 5'b10000, 0, 0);
    end
    chk("stuck_e",  32'(bus.fault),    32'h10);
    chk("stuck_dg", 32'(bus.degraded), 32'd1);
    chk("stuck_ft", 32'(bus.fatal),    32'd0);

    // a,b,c opposite z
    step(1, 0, 5'b00000, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 5'b00111, 0, 0);
    chk("three_f",  32'(bus.fault), 32'h07);
    chk("three_ft", 32'(bus.fatal), 32'd1);

    // voter check: abcde=00111 (c,d,e=1) with z=0
    step(1, 0, 5'b00000, 0, 1);
    step(1, 1, 5'b11100, 0, 0);
    chk("verr_set", 32'(bus.voter_err), 32'd1);
    step(1, 1, 5'b00000, 0, 0);
    chk("verr_hold", 32'(bus.voter_err), 32'd1);
    step(1, 0, 5'b00000, 0, 1);
    chk("verr_clr", 32'(bus.voter_err), 32'd0);

    // clr coincident with 3rd mismatch of d
    step(1, 1, 5'b01000, 0, 0);
    step(1, 1, 5'b01000, 0, 0);
    step(1, 1, 5'b01000, 0, 1);
    chk("clr_win", 32'(bus.fault), 32'd0);
    step(1, 1, 5'b01000, 0, 0);
    step(1, 1, 5'b01000, 0, 0);
    chk("d_healthy", 32'(bus.fault), 32'd0);
    chk("sat2",      32'(bus2.err_count), 32'd3);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      base = 1'($urandom);
      r = {5{base}};
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      zz = ($countones(r) >= 3);
      if ($urandom_range(0, 15) == 0) zz = ~zz;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, r, zz,
           $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
